ms_timer_sched: RTL and testbench

//  Shares one external 1 ms tick generator among NUM_CH independent timeout channels
//  (dot-hold, inter-character gap, answer window, etc.).

---
 rtl/ms_timer_pkg.sv | 15 +
 rtl/ms_chan_cnt.sv | 60 ++++++
 rtl/ms_timer_sched.sv | 86 ++++++++
 tb/tb_ms_timer_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_timer_pkg.sv
// Shared definitions for the 1 ms timeout scheduler: scheduler state encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ms_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    localparam int NUM_CH_DEF = 4;
    localparam int DUR_W_DEF  = 10;

endpackage

// File: rtl/ms_chan_cnt.sv
// One timeout channel: loads a ms duration on start, counts qualified ticks down, pulses done at expiry.
// Latency: busy/cnt update the cycle after start; done registered on the tick that takes cnt 1->0.
// Backpressure: none; cancel beats start, start beats tick.
module ms_chan_cnt
    import ms_timer_pkg::*;
#(
    parameter int DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [DUR_W-1:0] dur_ms,
    input  logic             tick,
    output logic             busy,
    output logic             done,
    output logic [DUR_W-1:0] cnt,
    output logic             busy_nxt
);

    logic             busy_d;
    logic             done_d;
    logic [DUR_W-1:0] cnt_d;

    always_comb begin
        busy_d = busy;
        done_d = 1'b0;
        cnt_d  = cnt;
        if (cancel) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            cnt_d  = dur_ms;
            busy_d = (dur_ms != '0);
            done_d = (dur_ms == '0);
        end else if (tick && busy) begin
            cnt_d = cnt - DUR_W'(1);
            if (cnt == DUR_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // The scheduler needs next-cycle occupancy so tick_en can drop together with busy.
    assign busy_nxt = busy_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            busy <= busy_d;
            done <= done_d;
            cnt  <= cnt_d;
        end
    end

endmodule

// File: rtl/ms_timer_sched.sv
// Shares one 1 ms tick generator among NUM_CH timeout channels; `PAUSE_EN adds a pause input that freezes them.
// Latency: all outputs registered; dur 0 -> done next cycle; expiry done registered on the qualifying tick.
// Backpressure: none; start/cancel are fire-and-forget pulses, tick_en gates the generator while any channel is busy.
module ms_timer_sched
    import ms_timer_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DUR_W  = DUR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [NUM_CH*DUR_W-1:0] dur_ms,
    input  logic                    tick_1ms,
`ifdef PAUSE_EN
    input  logic                    pause,
`endif
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic                    tick_en,
    output logic                    tick_rst_n
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic             en_prev;
    logic             pause_eff;
    logic             tick_q;
    logic [NUM_CH-1:0] busy_nxt;
    logic [DUR_W-1:0] chan_cnt [NUM_CH];

`ifdef PAUSE_EN
    assign pause_eff = pause;
`else
    assign pause_eff = 1'b0;
`endif

    // A tick only counts once the generator has been enabled for a full cycle, so a
    // pulse left over from reset, re-phase or pause (possibly X at power-up) is dropped.
    assign tick_q = (state == RUN) && en_prev && tick_1ms && !pause_eff;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|busy_nxt)  state_nxt = ARM;
            ARM:                     state_nxt = RUN;
            RUN:     if (!(|busy_nxt)) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tick_en    <= 1'b0;
            tick_rst_n <= 1'b0;
            en_prev    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_en    <= (state_nxt == RUN) && !pause_eff;
            tick_rst_n <= (state_nxt != ARM);
            en_prev    <= tick_en;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ms_chan_cnt #(
            .DUR_W(DUR_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .start    (start[i]),
            .cancel   (cancel[i]),
            .dur_ms   (dur_ms[i*DUR_W +: DUR_W]),
            .tick     (tick_q),
            .busy     (busy[i]),
            .done     (done[i]),
            .cnt      (chan_cnt[i]),
            .busy_nxt (busy_nxt[i])
        );

        a_busy_cnt: assert property (@(posedge clk) disable iff (!rst) busy[i] == (chan_cnt[i] != '0));
    end

endmodule

// File: tb/tb_ms_timer_sched.sv
// Self-checking bench for ms_timer_sched: directed scenarios plus randomized traffic against a remaining-ms model.
// A small generator model in the bench produces tick_1ms from tick_en/tick_rst_n with a short period.
module tb_ms_timer_sched;

    localparam int NCH    = 4;
    localparam int DW     = 10;
    localparam int PERIOD = 6;

    localparam int PH_IDLE = 0;
    localparam int PH_ARM  = 1;
    localparam int PH_RUN  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    start;
    logic [NCH-1:0]    cancel;
    logic [NCH*DW-1:0] dur_ms;
    logic              tick_1ms;
    logic              pause_v;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
    logic              tick_en;
    logic              tick_rst_n;

    always #5 clk = ~clk;

    ms_timer_sched #(.NUM_CH(NCH), .DUR_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cancel     (cancel),
        .dur_ms     (dur_ms),
        .tick_1ms   (tick_1ms),
`ifdef PAUSE_EN
        .pause      (pause_v),
`endif
        .busy       (busy),
        .done       (done),
        .tick_en    (tick_en),
        .tick_rst_n (tick_rst_n)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int ticks_seen;
    int g_cnt;
    bit junk_en;

    // Reference: remaining ms per channel; a channel is busy while anything remains.
    int             m_rem [NCH];
    logic [NCH-1:0] m_done;
    int             m_phase;
    logic           m_en, m_rstn, m_en_prev;

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = (m_rem[i] > 0);
        return b;
    endfunction

    task automatic model_edge(input logic r, input logic [NCH-1:0] s, input logic [NCH-1:0] c,
                              input logic [NCH*DW-1:0] d, input logic t, input logic p);
        bit q;
        int nbusy;
        int dv;
        if (r !== 1'b1) begin
            for (int i = 0; i < NCH; i++) m_rem[i] = 0;
            m_done = '0; m_phase = PH_IDLE; m_en = 1'b0; m_rstn = 1'b0; m_en_prev = 1'b0;
        end else begin
            q = (m_phase == PH_RUN) && (m_en_prev == 1'b1) && (t === 1'b1) && !p;
            nbusy = 0;
            for (int i = 0; i < NCH; i++) begin
                m_done[i] = 1'b0;
                dv = int'(d[i*DW +: DW]);
                if (c[i]) m_rem[i] = 0;
                else if (s[i]) begin
                    m_rem[i] = dv;
                    if (dv == 0) m_done[i] = 1'b1;
                end else if (q && m_rem[i] > 0) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) m_done[i] = 1'b1;
                end
                if (m_rem[i] > 0) nbusy++;
            end
            m_en_prev = m_en;
            if (m_phase == PH_IDLE)     m_phase = (nbusy > 0) ? PH_ARM : PH_IDLE;
            else if (m_phase == PH_ARM) m_phase = PH_RUN;
            else                        m_phase = (nbusy > 0) ? PH_RUN : PH_IDLE;
            m_en   = (m_phase == PH_RUN) && !p;
            m_rstn = (m_phase != PH_ARM);
        end
    endtask

    task automatic set_dur(input int ch, input int v);
        dur_ms[ch*DW +: DW] = DW'(v);
    endtask

    // One clock: capture the inputs the edge sees, update the model, run the generator model.
    task automatic step();
        logic r, t, p;
        logic [NCH-1:0] s, c;
        logic [NCH*DW-1:0] d;
        r = rst; s = start; c = cancel; d = dur_ms; t = tick_1ms; p = pause_v;
        if (t === 1'b1 && tick_en === 1'b1 && !p) ticks_seen++;
        @(posedge clk);
        #1;
        model_edge(r, s, c, d, t, p);
        start  = '0;
        cancel = '0;
        if (tick_rst_n !== 1'b1) begin
            g_cnt = 0;
            tick_1ms = 1'b0;
        end else if (tick_en === 1'b1) begin
            g_cnt++;
            if (g_cnt >= PERIOD) begin
                g_cnt = 0;
                tick_1ms = 1'b1;
            end else tick_1ms = 1'b0;
        end else begin
            tick_1ms = junk_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = '0; cancel = '0; dur_ms = '0; tick_1ms = 1'bx; pause_v = 1'b0;
        junk_en = 1'b0; g_cnt = 0;
        repeat (3) step();
        n_chk++;
        if ({busy, done} !== 8'h00) $display("FAIL reset_chan: got busy=%b done=%b want 0000/0000", busy, done);
        else n_pass++;
        n_chk++;
        if ({tick_en, tick_rst_n} !== 2'b00) $display("FAIL reset_tick: got en=%b rst_n=%b want 0/0", tick_en, tick_rst_n);
        else n_pass++;
        rst = 1'b1;
        step();
        n_chk++;
        if ({busy, tick_en, tick_rst_n} !== {4'b0000, 1'b0, 1'b1})
            $display("FAIL reset_release: got busy=%b en=%b rst_n=%b want 0000/0/1", busy, tick_en, tick_rst_n);
        else n_pass++;
    endtask

    task automatic test_single();
        int n;
        set_dur(0, 3); start[0] = 1'b1;
        step();
        n_chk++;
        if ({busy, tick_en, tick_rst_n} !== {4'b0001, 1'b0, 1'b0})
            $display("FAIL arm_cycle: got busy=%b en=%b rst_n=%b want 0001/0/0", busy, tick_en, tick_rst_n);
        else n_pass++;
        step();
        n_chk++;
        if ({tick_en, tick_rst_n} !== 2'b11) $display("FAIL run_enable: got en=%b rst_n=%b want 1/1", tick_en, tick_rst_n);
        else n_pass++;
        n = 2;
        while (done[0] !== 1'b1 && n < 200) begin step(); n++; end
        n_chk++;
        if (n != 2 + 3 * PERIOD) $display("FAIL single_latency: got %0d cycles want %0d", n, 2 + 3 * PERIOD);
        else n_pass++;
        n_chk++;
        if ({busy, tick_en, tick_rst_n} !== {4'b0000, 1'b0, 1'b1})
            $display("FAIL single_idle: got busy=%b en=%b rst_n=%b want 0000/0/1", busy, tick_en, tick_rst_n);
        else n_pass++;
        step();
        n_chk++;
        if (done !== 4'b0000) $display("FAIL single_done_pulse: got done=%b want 0000", done);
        else n_pass++;
    endtask

    task automatic test_zero_dur();
        set_dur(1, 0); start[1] = 1'b1;
        step();
        n_chk++;
        if ({done, busy, tick_en, tick_rst_n} !== {4'b0010, 4'b0000, 1'b0, 1'b1})
            $display("FAIL zero_dur: got done=%b busy=%b en=%b rst_n=%b want 0010/0000/0/1", done, busy, tick_en, tick_rst_n);
        else n_pass++;
        step();
        n_chk++;
        if ({done, busy, tick_rst_n} !== {4'b0000, 4'b0000, 1'b1})
            $display("FAIL zero_dur_idle: got done=%b busy=%b rst_n=%b want 0000/0000/1", done, busy, tick_rst_n);
        else n_pass++;
    endtask

    task automatic test_overlap();
        int d0, d2, en_gap;
        d0 = -1; d2 = -1; en_gap = 0; ticks_seen = 0;
        set_dur(0, 5); start[0] = 1'b1;
        for (int k = 0; k < 400 && d0 < 0; k++) begin
            step();
            if (done[2] === 1'b1) d2 = ticks_seen;
            if (done[0] === 1'b1) d0 = ticks_seen;
            else if (k >= 1 && tick_en !== 1'b1) en_gap++;
            if (tick_1ms === 1'b1 && ticks_seen == 0) begin set_dur(2, 2); start[2] = 1'b1; end
        end
        n_chk++;
        if (d2 != 3) $display("FAIL overlap_ch2: got done at tick %0d want 3", d2);
        else n_pass++;
        n_chk++;
        if (d0 != 5) $display("FAIL overlap_ch0: got done at tick %0d want 5", d0);
        else n_pass++;
        n_chk++;
        if (en_gap != 0 || tick_en !== 1'b0)
            $display("FAIL overlap_enable: got %0d gaps, final en=%b want 0 gaps, en=0", en_gap, tick_en);
        else n_pass++;
    endtask

    task automatic test_restart();
        int d0;
        d0 = -1; ticks_seen = 0;
        set_dur(0, 2); start[0] = 1'b1;
        for (int k = 0; k < 400 && d0 < 0; k++) begin
            step();
            if (done[0] === 1'b1) d0 = ticks_seen;
            if (tick_1ms === 1'b1 && ticks_seen == 1) begin set_dur(0, 4); start[0] = 1'b1; end
        end
        n_chk++;
        if (d0 != 6) $display("FAIL restart_on_tick: got done at tick %0d want 6", d0);
        else n_pass++;
    endtask

    task automatic test_cancel();
        int n, bad;
        n = 0; bad = 0; ticks_seen = 0;
        set_dur(3, 6); start[3] = 1'b1;
        while (ticks_seen < 2 && n < 200) begin
            step(); n++;
            if (done !== 4'b0000) bad++;
        end
        n_chk++;
        if (ticks_seen != 2 || bad != 0) $display("FAIL cancel_wait: got ticks=%0d dones=%0d want 2/0", ticks_seen, bad);
        else n_pass++;
        cancel = 4'b1010; set_dur(1, 3); start[1] = 1'b1;
        step();
        n_chk++;
        if ({busy, done, tick_en} !== 9'h000)
            $display("FAIL cancel_now: got busy=%b done=%b en=%b want 0000/0000/0", busy, done, tick_en);
        else n_pass++;
        bad = 0;
        repeat (30) begin
            step();
            if (done !== 4'b0000 || busy !== 4'b0000 || tick_rst_n !== 1'b1) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL cancel_quiet: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        set_dur(0, 1); start[0] = 1'b1;
        do begin step(); n++; end while (!(tick_1ms === 1'b1 && tick_en === 1'b1) && n < 200);
        rst = 1'b0;
        step();
        n_chk++;
        if ({busy, done, tick_en, tick_rst_n} !== 10'h000)
            $display("FAIL reset_mid: got busy=%b done=%b en=%b rst_n=%b want all 0", busy, done, tick_en, tick_rst_n);
        else n_pass++;
        rst = 1'b1;
        step();
        n_chk++;
        if ({busy, done} !== 8'h00) $display("FAIL reset_mid_after: got busy=%b done=%b want 0000/0000", busy, done);
        else n_pass++;
    endtask

`ifdef PAUSE_EN
    task automatic test_pause();
        int n, bad;
        n = 0; bad = 0; ticks_seen = 0;
        set_dur(0, 3); start[0] = 1'b1;
        while (ticks_seen < 1 && n < 200) begin step(); n++; end
        pause_v = 1'b1;
        step();
        for (int k = 0; k < 1000; k++) begin
            if (tick_en !== 1'b0 || busy[0] !== 1'b1 || done !== 4'b0000) bad++;
            if ($urandom_range(0, 7) == 0) tick_1ms = 1'b1;
            step();
        end
        n_chk++;
        if (bad != 0) $display("FAIL pause_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
        pause_v = 1'b0; ticks_seen = 0; n = 0;
        while (done[0] !== 1'b1 && n < 200) begin step(); n++; end
        n_chk++;
        if (ticks_seen != 2) $display("FAIL pause_resume: got done after %0d ticks want 2", ticks_seen);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        junk_en = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) begin start[i] = 1'b1; set_dur(i, $urandom_range(0, 3)); end
                if ($urandom_range(0, 40) == 0) cancel[i] = 1'b1;
            end
`ifdef PAUSE_EN
            if ($urandom_range(0, 60) == 0) pause_v = !pause_v;
`endif
            rst = ($urandom_range(0, 700) != 0);
            step();
            n_chk++;
            if ({busy, done, tick_en, tick_rst_n} !== {m_busy(), m_done, m_en, m_rstn})
                $display("FAIL random_cycle%0d: got busy=%b done=%b en=%b rst_n=%b want %b/%b/%b/%b",
                         k, busy, done, tick_en, tick_rst_n, m_busy(), m_done, m_en, m_rstn);
            else n_pass++;
        end
        rst = 1'b1; pause_v = 1'b0; junk_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_dur();
        test_overlap();
        test_restart();
        test_cancel();
        test_reset_mid();
`ifdef PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
